// File: rtl/ex_alu_ctrl.sv
// Execute-stage ALU control: registered opcode decode plus an iterative mult/div
// sequencer owning HI/LO, built only when ALU_CTRL_MULDIV_EN is defined.
//
// state    | meaning
// ST_IDLE  | no sequence running, decode accepts new instructions
// ST_MUL   | shift-add multiply, one multiplier bit per cycle
// ST_DIV   | restoring divide, one quotient bit per cycle
// ST_FIX   | sign correction and HI/LO write-back
module ex_alu_ctrl #(
    parameter int N_BITS_FUNC = 6,
    parameter int N_BITS_OP   = 3,
    parameter int N_BITS_CTRL = 4,
    parameter int N_BITS_DATA = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_flush,
    input  logic [N_BITS_OP-1:0]   i_alu_op,
    input  logic [N_BITS_FUNC-1:0] i_funcion,
    input  logic [N_BITS_DATA-1:0] i_rs_data,
    input  logic [N_BITS_DATA-1:0] i_rt_data,
    output logic [N_BITS_CTRL-1:0] o_alu_ctrl,
    output logic                   o_valid,
    output logic                   o_invalid,
    output logic                   o_stall,
    output logic [N_BITS_DATA-1:0] o_hi,
    output logic [N_BITS_DATA-1:0] o_lo
);

    localparam logic [N_BITS_CTRL-1:0] C_AND  = N_BITS_CTRL'(4'b0000);
    localparam logic [N_BITS_CTRL-1:0] C_OR   = N_BITS_CTRL'(4'b0001);
    localparam logic [N_BITS_CTRL-1:0] C_ADD  = N_BITS_CTRL'(4'b0010);
    localparam logic [N_BITS_CTRL-1:0] C_NOR  = N_BITS_CTRL'(4'b0011);
    localparam logic [N_BITS_CTRL-1:0] C_XOR  = N_BITS_CTRL'(4'b0100);
    localparam logic [N_BITS_CTRL-1:0] C_SLL  = N_BITS_CTRL'(4'b0101);
    localparam logic [N_BITS_CTRL-1:0] C_SUB  = N_BITS_CTRL'(4'b0110);
    localparam logic [N_BITS_CTRL-1:0] C_SLT  = N_BITS_CTRL'(4'b0111);
    localparam logic [N_BITS_CTRL-1:0] C_SRL  = N_BITS_CTRL'(4'b1000);
    localparam logic [N_BITS_CTRL-1:0] C_SRA  = N_BITS_CTRL'(4'b1001);
    localparam logic [N_BITS_CTRL-1:0] C_ILL  = N_BITS_CTRL'(4'b1010);
    localparam logic [N_BITS_CTRL-1:0] C_LUI  = N_BITS_CTRL'(4'b1011);

    localparam logic [N_BITS_FUNC-1:0] F_AND  = N_BITS_FUNC'(6'b100100);
    localparam logic [N_BITS_FUNC-1:0] F_OR   = N_BITS_FUNC'(6'b100101);
    localparam logic [N_BITS_FUNC-1:0] F_ADD  = N_BITS_FUNC'(6'b100000);
    localparam logic [N_BITS_FUNC-1:0] F_ADDU = N_BITS_FUNC'(6'b100001);
    localparam logic [N_BITS_FUNC-1:0] F_NOR  = N_BITS_FUNC'(6'b100111);
    localparam logic [N_BITS_FUNC-1:0] F_XOR  = N_BITS_FUNC'(6'b100110);
    localparam logic [N_BITS_FUNC-1:0] F_SLL  = N_BITS_FUNC'(6'b000000);
    localparam logic [N_BITS_FUNC-1:0] F_SUB  = N_BITS_FUNC'(6'b100010);
    localparam logic [N_BITS_FUNC-1:0] F_SUBU = N_BITS_FUNC'(6'b100011);
    localparam logic [N_BITS_FUNC-1:0] F_SLT  = N_BITS_FUNC'(6'b101010);
    localparam logic [N_BITS_FUNC-1:0] F_SRL  = N_BITS_FUNC'(6'b000010);
    localparam logic [N_BITS_FUNC-1:0] F_SRA  = N_BITS_FUNC'(6'b000011);

    logic [N_BITS_CTRL-1:0] dec_ctrl;
    logic                   dec_invalid;
    logic                   busy;

`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [N_BITS_CTRL-1:0] C_MFHI = N_BITS_CTRL'(4'b1100);
    localparam logic [N_BITS_CTRL-1:0] C_MFLO = N_BITS_CTRL'(4'b1101);
    localparam logic [N_BITS_CTRL-1:0] C_NOP  = N_BITS_CTRL'(4'b1110);
    localparam logic [N_BITS_FUNC-1:0] F_MFHI  = N_BITS_FUNC'(6'b010000);
    localparam logic [N_BITS_FUNC-1:0] F_MFLO  = N_BITS_FUNC'(6'b010010);
    localparam logic [N_BITS_FUNC-1:0] F_MULT  = N_BITS_FUNC'(6'b011000);
    localparam logic [N_BITS_FUNC-1:0] F_MULTU = N_BITS_FUNC'(6'b011001);
    localparam logic [N_BITS_FUNC-1:0] F_DIV   = N_BITS_FUNC'(6'b011010);
    localparam logic [N_BITS_FUNC-1:0] F_DIVU  = N_BITS_FUNC'(6'b011011);
    logic dec_muldiv;
`endif

    always_comb begin
        dec_ctrl    = C_ILL;
        dec_invalid = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        dec_muldiv  = 1'b0;
`endif
        case (i_alu_op)
            N_BITS_OP'(3'b000): dec_ctrl = C_ADD;
            N_BITS_OP'(3'b001): dec_ctrl = C_SUB;
            N_BITS_OP'(3'b011): dec_ctrl = C_AND;
            N_BITS_OP'(3'b100): dec_ctrl = C_OR;
            N_BITS_OP'(3'b101): dec_ctrl = C_XOR;
            N_BITS_OP'(3'b110): dec_ctrl = C_SLT;
            N_BITS_OP'(3'b111): dec_ctrl = C_LUI;
            N_BITS_OP'(3'b010): begin
                case (i_funcion)
                    F_AND:          dec_ctrl = C_AND;
                    F_OR:           dec_ctrl = C_OR;
                    F_ADD, F_ADDU:  dec_ctrl = C_ADD;
                    F_NOR:          dec_ctrl = C_NOR;
                    F_XOR:          dec_ctrl = C_XOR;
                    F_SLL:          dec_ctrl = C_SLL;
                    F_SUB, F_SUBU:  dec_ctrl = C_SUB;
                    F_SLT:          dec_ctrl = C_SLT;
                    F_SRL:          dec_ctrl = C_SRL;
                    F_SRA:          dec_ctrl = C_SRA;
`ifdef ALU_CTRL_MULDIV_EN
                    F_MFHI:         dec_ctrl = C_MFHI;
                    F_MFLO:         dec_ctrl = C_MFLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        dec_ctrl   = C_NOP;
                        dec_muldiv = 1'b1;
                    end
`endif
                    default: begin
                        dec_ctrl    = C_ILL;
                        dec_invalid = 1'b1;
                    end
                endcase
            end
            default: dec_ctrl = C_ILL;
        endcase
    end

    logic [N_BITS_CTRL-1:0] ctrl_q, ctrl_d;
    logic                   valid_q, valid_d;
    logic                   invalid_q, invalid_d;

    // A running sequence freezes the decode register so the held instruction
    // is decoded only once the sequencer is back in IDLE.
    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        if (!busy) begin
            ctrl_d    = dec_ctrl;
            valid_d   = i_valid & ~i_flush;
            invalid_d = i_valid & ~i_flush & dec_invalid;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q    <= C_ILL;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
        end
    end

    assign o_alu_ctrl = ctrl_q;
    assign o_valid    = valid_q;
    assign o_invalid  = invalid_q;

`ifdef ALU_CTRL_MULDIV_EN
    localparam int CNT_W = $clog2(N_BITS_DATA + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_BITS_DATA-1:0] opnd_q, opnd_d;
    logic [N_BITS_DATA-1:0] work_hi_q, work_hi_d;
    logic [N_BITS_DATA-1:0] work_lo_q, work_lo_d;
    logic [N_BITS_DATA-1:0] hi_q, hi_d;
    logic [N_BITS_DATA-1:0] lo_q, lo_d;
    logic                   is_mul_q, is_mul_d;
    logic                   neg_lo_q, neg_lo_d;
    logic                   neg_hi_q, neg_hi_d;
    logic                   stall_q, stall_d;

    logic                   start, op_signed, op_div, a_neg, b_neg;
    logic [N_BITS_DATA-1:0] a_mag, b_mag;
    logic [N_BITS_DATA:0]   mul_sum, div_shift, div_diff;
    logic                   div_ge;
    logic [2*N_BITS_DATA-1:0] prod_raw, prod_neg;

    assign start     = i_valid & dec_muldiv & ~i_flush & (state_q == ST_IDLE);
    assign op_signed = ~i_funcion[0];
    assign op_div    = i_funcion[1];
    assign a_neg     = op_signed & i_rs_data[N_BITS_DATA-1];
    assign b_neg     = op_signed & i_rt_data[N_BITS_DATA-1];
    assign a_mag     = a_neg ? -i_rs_data : i_rs_data;
    assign b_mag     = b_neg ? -i_rt_data : i_rt_data;

    // MUL keeps the product in {work_hi, work_lo}; DIV keeps remainder/quotient there.
    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {work_hi_q, work_lo_q[N_BITS_DATA-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod_raw  = {work_hi_q, work_lo_q};
    assign prod_neg  = -prod_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_mul_d  = is_mul_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = CNT_W'(N_BITS_DATA);
                    opnd_d    = b_mag;
                    is_mul_d  = ~op_div;
                    work_hi_d = '0;
                    work_lo_d = a_mag;
                    neg_lo_d  = a_neg ^ b_neg;
                    neg_hi_d  = op_div ? a_neg : (a_neg ^ b_neg);
                    if (op_div && i_rt_data == '0) begin
                        state_d   = ST_FIX;
                        work_hi_d = i_rs_data;
                        work_lo_d = '1;
                        neg_lo_d  = 1'b0;
                        neg_hi_d  = 1'b0;
                    end else begin
                        state_d = op_div ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                work_hi_d = mul_sum[N_BITS_DATA:1];
                work_lo_d = {mul_sum[0], work_lo_q[N_BITS_DATA-1:1]};
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                work_hi_d = div_ge ? div_diff[N_BITS_DATA-1:0] : div_shift[N_BITS_DATA-1:0];
                work_lo_d = {work_lo_q[N_BITS_DATA-2:0], div_ge};
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            default: begin
                if (is_mul_q) begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : prod_raw;
                end else begin
                    lo_d = neg_lo_q ? -work_lo_q : work_lo_q;
                    hi_d = neg_hi_q ? -work_hi_q : work_hi_q;
                end
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
        stall_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_mul_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_mul_q  <= is_mul_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            stall_q   <= stall_d;
        end
    end

    assign busy    = stall_q;
    assign o_stall = stall_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
`else
    logic unused_operands;
    assign unused_operands = ^{i_rs_data, i_rt_data};
    assign busy    = 1'b0;
    assign o_stall = 1'b0;
    assign o_hi    = '0;
    assign o_lo    = '0;
`endif

endmodule

// File: tb/tb_ex_alu_ctrl.sv
// Self-checking bench for ex_alu_ctrl: directed and random decode, plus mult/div
// sequencing against an arithmetic reference when ALU_CTRL_MULDIV_EN is defined.
module tb_ex_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, flush;
    logic [2:0]  op;
    logic [5:0]  funct;
    logic [31:0] rs, rt;
    logic [3:0]  alu_ctrl;
    logic        o_valid, o_invalid, o_stall;
    logic [31:0] o_hi, o_lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    ex_alu_ctrl dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_valid    (valid),
        .i_flush    (flush),
        .i_alu_op   (op),
        .i_funcion  (funct),
        .i_rs_data  (rs),
        .i_rt_data  (rt),
        .o_alu_ctrl (alu_ctrl),
        .o_valid    (o_valid),
        .o_invalid  (o_invalid),
        .o_stall    (o_stall),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_dec(input logic [2:0] o, input logic [5:0] f, input bit en,
                                      output logic [3:0] c, output logic inv);
        inv = 1'b0;
        case (o)
            3'd0: c = 4'b0010;
            3'd1: c = 4'b0110;
            3'd3: c = 4'b0000;
            3'd4: c = 4'b0001;
            3'd5: c = 4'b0100;
            3'd6: c = 4'b0111;
            3'd7: c = 4'b1011;
            default: begin
                case (f)
                    6'b100100: c = 4'b0000;
                    6'b100101: c = 4'b0001;
                    6'b100000, 6'b100001: c = 4'b0010;
                    6'b100111: c = 4'b0011;
                    6'b100110: c = 4'b0100;
                    6'b000000: c = 4'b0101;
                    6'b100010, 6'b100011: c = 4'b0110;
                    6'b101010: c = 4'b0111;
                    6'b000010: c = 4'b1000;
                    6'b000011: c = 4'b1001;
                    6'b010000: c = en ? 4'b1100 : 4'b1010;
                    6'b010010: c = en ? 4'b1101 : 4'b1010;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: c = en ? 4'b1110 : 4'b1010;
                    default: c = 4'b1010;
                endcase
                inv = (c == 4'b1010);
            end
        endcase
    endfunction

    function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = 32'd0;
        lo = 32'd0;
        if (f[1] && b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (!f[1]) begin
            p = f[0] ? (ua * ub) : (sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (f[0]) begin
            lo = 32'(ua / ub);
            hi = 32'(ua % ub);
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            lo = sq[31:0];
            hi = sr[31:0];
        end
    endfunction

    // Starts a mult/div from the cycle after an edge; returns with inputs idle.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit then_mflo);
        int n;
        valid = 1'b1; flush = 1'b0; op = 3'd2; funct = f; rs = a; rt = b;
        tick();
        chk({tag, "_start_ctrl"}, alu_ctrl, 4'b1110);
        chk({tag, "_start_valid"}, o_valid, 1'b1);
        chk({tag, "_start_stall"}, o_stall, 1'b1);
        valid = then_mflo; funct = 6'b010010;
        n = 0;
        while (o_stall && n < 100) begin
            n++;
            tick();
            if (n == 1) chk({tag, "_valid_drop"}, o_valid, 1'b0);
            if (n == 1 && o_stall) chk({tag, "_hi_hold"}, o_hi, model_hi);
        end
        chk({tag, "_stall_len"}, n, exp_stall);
        chk({tag, "_hi"}, o_hi, ehi);
        chk({tag, "_lo"}, o_lo, elo);
        model_hi = ehi;
        model_lo = elo;
        if (then_mflo) begin
            tick();
            chk({tag, "_mflo_ctrl"}, alu_ctrl, 4'b1101);
            chk({tag, "_mflo_valid"}, o_valid, 1'b1);
            valid = 1'b0;
        end
    endtask

    initial begin
        logic [5:0]  flist [16];
        logic [3:0]  ec;
        logic        ei, ev;
        logic [31:0] ehi, elo, a, b;
        logic [5:0]  f;
        flist = '{6'b100100, 6'b100101, 6'b100000, 6'b100001, 6'b100111, 6'b100110,
                  6'b000000, 6'b100010, 6'b100011, 6'b101010, 6'b000010, 6'b000011,
                  6'b010000, 6'b010010, 6'b011000, 6'b011011};

        rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 3'd0; funct = 6'd0; rs = 32'd0; rt = 32'd0;
        #2;
        chk("rst_ctrl", alu_ctrl, 4'b1010);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_invalid", o_invalid, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_hi", o_hi, 32'd0);
        chk("rst_lo", o_lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        valid = 1'b1; op = 3'd2; funct = 6'b100000;
        tick();
        chk("dec_add_ctrl", alu_ctrl, 4'b0010);
        chk("dec_add_valid", o_valid, 1'b1);
        chk("dec_add_inv", o_invalid, 1'b0);
        op = 3'd7;
        tick();
        chk("dec_lui_ctrl", alu_ctrl, 4'b1011);
        op = 3'd2; funct = 6'b111111;
        tick();
        chk("dec_ill_ctrl", alu_ctrl, 4'b1010);
        chk("dec_ill_inv", o_invalid, 1'b1);
        funct = 6'b011000;
        tick();
        chk("dec_mult_ctrl", alu_ctrl, MD_EN ? 4'b1110 : 4'b1010);
        chk("dec_mult_inv", o_invalid, !MD_EN);
        valid = 1'b0;
        if (MD_EN) begin
            while (o_stall) tick();
        end else begin
            repeat (3) begin
                tick();
                chk("dis_no_stall", o_stall, 1'b0);
            end
        end
        model_hi = o_hi;
        if (MD_EN) begin
            md_model(6'b011000, 32'd0, 32'd0, ehi, elo);
            chk("mult_zero_hi", o_hi, ehi);
            chk("mult_zero_lo", o_lo, elo);
        end
        tick();

        for (int i = 0; i < 80; i++) begin
            op    = 3'($urandom_range(0, 7));
            funct = ($urandom % 2 == 0) ? flist[$urandom_range(0, 15)] : 6'($urandom);
            if (MD_EN && op == 3'd2 && funct inside {[6'b011000:6'b011011]}) funct = 6'b100010;
            valid = ($urandom % 4) != 0;
            flush = ($urandom % 5) == 0;
            tick();
            model_dec(op, funct, MD_EN, ec, ei);
            ev = valid & ~flush;
            chk("rnd_valid", o_valid, ev);
            chk("rnd_stall", o_stall, 1'b0);
            if (ev) begin
                chk("rnd_ctrl", alu_ctrl, ec);
                chk("rnd_inv", o_invalid, ei);
            end else begin
                chk("rnd_inv_idle", o_invalid, 1'b0);
            end
        end
        valid = 1'b0; flush = 1'b0;
        tick();

`ifdef ALU_CTRL_MULDIV_EN
        run_md("mult_neg", 6'b011000, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        run_md("div_neg", 6'b011010, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_md("divu_zero", 6'b011011, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            f = 6'b011000 | 6'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            md_model(f, a, b, ehi, elo);
            run_md("rnd_md", f, a, b, (f[1] && b == 32'd0) ? 1 : 33, ehi, elo, 1'b0);
        end

        valid = 1'b1; op = 3'd2; funct = 6'b011001; rs = 32'd3; rt = 32'd4;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        chk("flush_pre_stall", o_stall, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_stall", o_stall, 1'b0);
        chk("flush_valid", o_valid, 1'b0);
        chk("flush_hi", o_hi, model_hi);
        chk("flush_lo", o_lo, model_lo);
        run_md("multu_after", 6'b011001, 32'd3, 32'd4, 33, 32'd0, 32'd12, 1'b0);

        valid = 1'b1; op = 3'd2; funct = 6'b011010; rs = 32'd100; rt = 32'd7;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", o_stall, 1'b0);
        chk("arst_hi", o_hi, 32'd0);
        chk("arst_lo", o_lo, 32'd0);
        chk("arst_ctrl", alu_ctrl, 4'b1010);
        chk("arst_valid", o_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_idle", o_stall, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
